// File: rtl/lstm_sample_sequencer.sv
// One-sample-in-flight sequencer: writes each sample to the LSTM block over AXI4-Lite, then returns y_out.
// Optional performance counters are enabled by defining LSTM_SEQ_PERF_EN.
module lstm_sample_sequencer #(
    parameter logic [31:0] SAMPLE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT     = 4096,
    parameter int          CNT_WIDTH   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    input  logic [15:0] y_out,
    input  logic        y_out_valid,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        err_resp,
    output logic        err_timeout,
    input  logic        err_clr
`ifdef LSTM_SEQ_PERF_EN
    ,
    output logic [31:0] perf_samples,
    output logic [31:0] perf_latency
`endif
);

    typedef enum logic [2:0] {IDLE, WRITE, RESP, WAIT_Y, OUT} state_t;

    state_t               state_reg, state_next;
    logic                 s_ready_reg, s_ready_next;
    logic                 awvalid_reg, awvalid_next;
    logic                 wvalid_reg, wvalid_next;
    logic                 bready_reg, bready_next;
    logic                 m_valid_reg, m_valid_next;
    logic [15:0]          sample_reg;
    logic [15:0]          m_data_reg;
    logic [15:0]          y_hold_reg;
    logic                 y_cap_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 err_resp_reg, err_timeout_reg;

    logic accept, aw_fin, w_fin, b_hs, y_avail, tmo, m_hs;

    assign accept  = (state_reg == IDLE) && s_valid && s_ready_reg;
    // A channel is finished once its valid has dropped or it is handshaking now.
    assign aw_fin  = !awvalid_reg || awready;
    assign w_fin   = !wvalid_reg || wready;
    assign b_hs    = bvalid && bready_reg;
    assign y_avail = y_cap_reg || y_out_valid;
    assign tmo     = (cnt_reg == CNT_WIDTH'(TIMEOUT - 1));
    assign m_hs    = m_valid_reg && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            s_ready_reg <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            m_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_ready_reg <= s_ready_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            m_valid_reg <= m_valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = WRITE;
            WRITE:   if (aw_fin && w_fin) state_next = RESP;
            RESP:    if (b_hs) state_next = (bresp == 2'b00) ? WAIT_Y : IDLE;
            WAIT_Y: begin
                if (y_avail)  state_next = OUT;
                else if (tmo) state_next = IDLE;
            end
            OUT:     if (m_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready_next = (state_next == IDLE);
        bready_next  = (state_next == RESP);
        m_valid_next = (state_next == OUT);
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        if (state_reg == IDLE) begin
            awvalid_next = accept;
            wvalid_next  = accept;
        end else if (state_reg == WRITE) begin
            awvalid_next = awvalid_reg && !awready;
            wvalid_next  = wvalid_reg && !wready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_reg      <= '0;
            m_data_reg      <= '0;
            y_hold_reg      <= '0;
            y_cap_reg       <= 1'b0;
            cnt_reg         <= '0;
            err_resp_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (accept)
                sample_reg <= s_data;
            if (state_reg == WAIT_Y && y_avail)
                m_data_reg <= y_cap_reg ? y_hold_reg : y_out;
            // Early results can arrive before the B handshake; the first one wins.
            if (state_next == IDLE) begin
                y_cap_reg <= 1'b0;
            end else if ((state_reg == WRITE || state_reg == RESP) && y_out_valid && !y_cap_reg) begin
                y_cap_reg  <= 1'b1;
                y_hold_reg <= y_out;
            end
            if (state_next == IDLE)
                cnt_reg <= '0;
            else if (state_reg == WAIT_Y)
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            if (err_clr)
                err_resp_reg <= 1'b0;
            else if (state_reg == RESP && b_hs && bresp != 2'b00)
                err_resp_reg <= 1'b1;
            if (err_clr)
                err_timeout_reg <= 1'b0;
            else if (state_reg == WAIT_Y && !y_avail && tmo)
                err_timeout_reg <= 1'b1;
        end
    end

`ifdef LSTM_SEQ_PERF_EN
    logic [31:0] perf_samples_reg, perf_latency_reg, lat_run_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_samples_reg <= '0;
            perf_latency_reg <= '0;
            lat_run_reg      <= '0;
        end else begin
            if (accept)
                lat_run_reg <= 32'd1;
            else if (lat_run_reg != 32'hFFFF_FFFF)
                lat_run_reg <= lat_run_reg + 32'd1;
            if (state_reg == OUT && m_hs) begin
                perf_samples_reg <= perf_samples_reg + 32'd1;
                perf_latency_reg <= lat_run_reg;
            end
        end
    end

    assign perf_samples = perf_samples_reg;
    assign perf_latency = perf_latency_reg;
`endif

    assign s_ready     = s_ready_reg;
    assign awaddr      = SAMPLE_ADDR;
    assign awprot      = 3'b000;
    assign awvalid     = awvalid_reg;
    assign wdata       = {{16{sample_reg[15]}}, sample_reg};
    assign wstrb       = 4'hF;
    assign wvalid      = wvalid_reg;
    assign bready      = bready_reg;
    assign m_data      = m_data_reg;
    assign m_valid     = m_valid_reg;
    assign busy        = (state_reg != IDLE);
    assign err_resp    = err_resp_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_lstm_sample_sequencer.sv
// Scoreboard bench for lstm_sample_sequencer: B-channel slave model plus write and result monitors.
module tb_lstm_sample_sequencer;

    localparam logic [31:0] ADDR = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] y_out;
    logic        y_out_valid;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        err_resp;
    logic        err_timeout;
    logic        err_clr;
`ifdef LSTM_SEQ_PERF_EN
    logic [31:0] perf_samples;
    logic [31:0] perf_latency;
`endif

    lstm_sample_sequencer #(.SAMPLE_ADDR(ADDR), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .y_out(y_out), .y_out_valid(y_out_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err_resp(err_resp), .err_timeout(err_timeout), .err_clr(err_clr)
`ifdef LSTM_SEQ_PERF_EN
        , .perf_samples(perf_samples), .perf_latency(perf_latency)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          aw_count = 0;
    int          w_count = 0;
    int          m_count = 0;
    int          b_count = 0;
    logic [31:0] exp_w[$];
    logic [15:0] exp_m[$];
    logic [1:0]  bresp_cfg = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write slave: B response one cycle after both AW and W handshakes.
    logic hs_aw, hs_w, hs_b, r_s, aw_got, w_got;
    initial begin
        bvalid = 1'b0;
        bresp  = 2'b00;
        aw_got = 1'b0;
        w_got  = 1'b0;
        forever begin
            @(negedge clk);
            r_s  = rst;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            @(posedge clk);
            #1;
            if (r_s) begin
                bvalid = 1'b0;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end else begin
                if (hs_aw) aw_got = 1'b1;
                if (hs_w)  w_got  = 1'b1;
                if (hs_b) begin
                    bvalid = 1'b0;
                    b_count++;
                end else if (aw_got && w_got && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = bresp_cfg;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
            end
        end
    end

    // Write-channel monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && awvalid && awready) begin
                aw_count++;
                check("awaddr", awaddr, ADDR);
                check("awprot", 32'(awprot), 32'd0);
            end
            if (!rst && wvalid && wready) begin
                w_count++;
                $display("write  wdata=%h wstrb=%h", wdata, wstrb);
                check("wstrb", 32'(wstrb), 32'hF);
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected: got wdata=%h required no write", wdata);
                end else begin
                    check("wdata", wdata, exp_w.pop_front());
                end
            end
        end
    end

    // Result monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                m_count++;
                $display("result m_data=%h", m_data);
                if (exp_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_unexpected: got m_data=%h required no result", m_data);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_m.pop_front()));
                end
            end
        end
    end

    task automatic send_sample(input logic [15:0] d);
        logic ok;
        ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("s_ready_seen", 32'(ok), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_b_neg();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bvalid && bready) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_handshake_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_b();
        wait_b_neg();
        tick();
    endtask

    task automatic strobe_y(input logic [15:0] v);
        y_out       = v;
        y_out_valid = 1'b1;
        tick();
        y_out_valid = 1'b0;
    endtask

    task automatic wait_mvalid();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("m_valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic take_result();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("m_valid_drop", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int aw0, w0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; awready = 1'b1; wready = 1'b1;
        y_out = '0; y_out_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("reset_outs", 32'({s_ready, awvalid, wvalid, bready, m_valid, busy, err_resp, err_timeout}), 32'd0);
        check("reset_mdata", 32'(m_data), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_s_ready", 32'(s_ready), 32'd1);

        // Zero-wait slave, negative sample, late result held under back-pressure
        exp_w.push_back(32'hFFFF_8001);
        exp_m.push_back(16'h1234);
        send_sample(16'h8001);
        check("t1_write_start", 32'({s_ready, awvalid, wvalid}), 32'b011);
        check("t1_wdata_live", wdata, 32'hFFFF_8001);
        wait_b();
        tick();
        tick();
        check("t1_no_early", 32'(m_valid), 32'd0);
        strobe_y(16'h1234);
        y_out = 16'hBEEF;
        wait_mvalid();
        for (int i = 0; i < 3; i++) begin
            check("t1_m_hold", 32'({m_valid, m_data}), {15'd0, 1'b1, 16'h1234});
            tick();
        end
        take_result();

        // AW handshake 4 cycles after W handshake
        aw0 = aw_count;
        w0  = w_count;
        awready = 1'b0;
        exp_w.push_back(32'h0000_0005);
        exp_m.push_back(16'h7FFF);
        send_sample(16'h0005);
        check("t2_both_valid", 32'({awvalid, wvalid}), 32'b11);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_aw_held", 32'({awvalid, wvalid, bready}), 32'b100);
            tick();
        end
        awready = 1'b1;
        tick();
        check("t2_resp_entry", 32'({awvalid, wvalid, bready}), 32'b001);
        wait_b();
        strobe_y(16'h7FFF);
        wait_mvalid();
        take_result();
        check("t2_one_aw", 32'(aw_count - aw0), 32'd1);
        check("t2_one_w", 32'(w_count - w0), 32'd1);

        // SLVERR response drops the sample
        bresp_cfg = 2'b10;
        exp_w.push_back(32'h0000_0101);
        send_sample(16'h0101);
        wait_b();
        bresp_cfg = 2'b00;
        check("t3_flags", 32'({s_ready, err_resp, busy, m_valid}), 32'b1100);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_clr", 32'(err_resp), 32'd0);
        check("t3_no_result", 32'(m_valid), 32'd0);

        // Result strobed in the same cycle as the B handshake
        exp_w.push_back(32'h0000_0202);
        exp_m.push_back(16'h0042);
        send_sample(16'h0202);
        wait_b_neg();
        y_out = 16'h0042;
        y_out_valid = 1'b1;
        tick();
        y_out_valid = 1'b0;
        y_out = 16'hDEAD;
        wait_mvalid();
        check("t4_captured", 32'(m_data), 32'h0042);
        take_result();

        // Timeout with no result, then a normal sample
        exp_w.push_back(32'h0000_0303);
        send_sample(16'h0303);
        wait_b();
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("t5_wait_cycles", 32'(n), 32'd8);
        check("t5_flags", 32'({err_timeout, m_valid, s_ready}), 32'b101);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_clr", 32'(err_timeout), 32'd0);
        exp_w.push_back(32'hFFFF_FFFE);
        exp_m.push_back(16'hABCD);
        send_sample(16'hFFFE);
        wait_b();
        strobe_y(16'hABCD);
        wait_mvalid();
        take_result();

        // Long back-pressure with a waiting sample, then reset mid-WRITE
        exp_w.push_back(32'h0000_1111);
        exp_m.push_back(16'h5555);
        send_sample(16'h1111);
        wait_b();
        strobe_y(16'h5555);
        wait_mvalid();
        s_data  = 16'h2222;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("t6_stall", 32'({s_ready, m_valid, m_data}), {14'd0, 1'b0, 1'b1, 16'h5555});
            tick();
        end
        awready = 1'b0;
        wready  = 1'b0;
        take_result();
        check("t6_idle_again", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("t7_in_write", 32'({busy, awvalid, wvalid}), 32'b111);
        rst = 1'b1;
        tick();
        check("t7_reset_outs", 32'({s_ready, awvalid, wvalid, bready, m_valid, busy, err_resp, err_timeout}), 32'd0);
        check("t7_reset_mdata", 32'(m_data), 32'd0);
        rst = 1'b0;
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        tick();
        check("t7_s_ready", 32'(s_ready), 32'd1);

        check("total_aw", 32'(aw_count), 32'd7);
        check("total_w", 32'(w_count), 32'd7);
        check("total_b", 32'(b_count), 32'd7);
        check("total_m", 32'(m_count), 32'd5);
        check("exp_w_left", 32'(exp_w.size()), 32'd0);
        check("exp_m_left", 32'(exp_m.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lstm_sample_sequencer.md
Name: lstm_sample_sequencer

Overview:
- AXI4-Lite write master that drives the LSTM layers block's AXI4-Lite slave port, and runs one inference per input sample.
- Accepts 16-bit samples on a valid/ready stream and writes each sample to the sample register at SAMPLE_ADDR.
- Waits for the layer stack's y_out_valid, then presents y_out on a valid/ready result stream.
- Sits between the sample source (ADC/DMA stream) and the LSTM layers wrapper. Only one sample is in flight at a time.

Parameters:
- SAMPLE_ADDR, 32'h0000_0000, byte address the sample is written to.
- TIMEOUT, 4096, maximum cycles in WAIT_Y before abort. Must be >= 2.
- CNT_WIDTH, $clog2(TIMEOUT+1), width of the timeout counter (derived; do not override).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  16  input sample, signed Q-format.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- awaddr  out  32  write address, constant SAMPLE_ADDR.
- awprot  out  3  constant 3'b000.
- awvalid  out  1  write address valid.
- awready  in  1  slave address ready.
- wdata  out  32  sample sign-extended to 32 bits.
- wstrb  out  4  constant 4'hF.
- wvalid  out  1  write data valid.
- wready  in  1  slave data ready.
- bresp  in  2  write response.
- bvalid  in  1  response valid.
- bready  out  1  response ready.
- y_out  in  16  layer-stack result.
- y_out_valid  in  1  one-cycle result strobe.
- m_data  out  16  result to consumer.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer ready.
- busy  out  1  high in any state other than IDLE.
- err_resp  out  1  sticky: a non-OKAY bresp was received.
- err_timeout  out  1  sticky: the TIMEOUT limit was reached.
- err_clr  in  1  one-cycle pulse that clears both sticky flags.

Behaviour:
- Reset values: state = IDLE. s_ready, awvalid, wvalid, bready, m_valid, busy, err_resp, err_timeout all 0. m_data = 0. Timeout counter = 0. y-captured flag = 0.
- The state is held in registers; s_ready, awvalid, wvalid, bready and m_valid are registered outputs.
- IDLE: s_ready = 1.
  - On s_valid & s_ready: latch s_data, go to WRITE.
  - s_ready drops in the cycle after acceptance.
- WRITE: awvalid and wvalid are raised together in the first WRITE cycle.
  - Each is held until its own handshake completes (awvalid & awready, wvalid & wready), then dropped independently.
  - awaddr and wdata stay stable while the corresponding valid is high.
  - When both handshakes are done (same cycle or different cycles), go to RESP.
- RESP: bready = 1.
  - On bvalid & bresp == 2'b00, go to WAIT_Y.
  - On bvalid & bresp != 0: set err_resp, drop the sample, go to IDLE. No result is emitted.
- y_out_valid is captured in either WRITE or RESP, because the datapath may finish before the B handshake. The captured value is held and used on entry to WAIT_Y.
- WAIT_Y: the counter increments every cycle.
  - On y_out_valid, or if a value is already captured: load m_data = y_out (or the captured value), go to OUT.
  - When the counter reaches TIMEOUT-1 with no result: set err_timeout, go to IDLE, emit nothing.
- OUT: m_valid = 1 with m_data held stable until m_ready. The handshake is the cycle with m_valid & m_ready; go to IDLE the next cycle.
- Back-pressure: m_ready low stalls in OUT indefinitely. No new sample is accepted until the result is taken.
- y_out_valid in IDLE or OUT is ignored. If a second strobe arrives before OUT, the first value is kept.
- err_clr has priority over a same-cycle set, so the flag reads 0. err_clr does not affect the FSM.
- The counter and the y-captured flag clear on every entry to IDLE.
- Reset mid-transaction returns to the reset state the next cycle, including any outstanding AW/W/B handshake. The slave is reset by the same rst.
- Minimum throughput with zero-wait slave and consumer: IDLE, WRITE, RESP, WAIT_Y, OUT = 5 cycles per sample, plus the datapath latency.

Optional Feature:
- Macro: LSTM_SEQ_PERF_EN.
- Defined: adds outputs perf_samples[31:0] and perf_latency[31:0].
  - perf_samples counts completed OUT handshakes and wraps at 2^32.
  - perf_latency holds the cycle count from s_ready acceptance to the OUT handshake of the last sample, and saturates at 32'hFFFF_FFFF.
  - Both reset to 0.
- Undefined: neither port nor the counters exist. Behaviour is otherwise identical.

Test Plan:
- Zero-wait slave; s_data = 16'h8001; y_out = 16'h1234 strobed 3 cycles after the B handshake -> wdata = 32'hFFFF_8001, wstrb = 4'hF, awaddr = SAMPLE_ADDR; m_data = 16'h1234 with m_valid high until m_ready.
- awready asserted 4 cycles after wready -> wvalid drops after its own handshake, awvalid held 4 cycles, exactly one write; RESP is entered only after both handshakes.
- bresp = 2'b10 -> err_resp = 1, m_valid never asserts, s_ready = 1 again 1 cycle after the B handshake; an err_clr pulse -> err_resp = 0.
- y_out_valid = 1 with y_out = 16'h0042 in the same cycle as bvalid -> value captured; m_data = 16'h0042 emitted without a further strobe.
- No y_out_valid, TIMEOUT = 8 -> err_timeout set after 8 WAIT_Y cycles, busy = 0 the next cycle; a following sample completes normally.
- m_ready held low 20 cycles with s_valid = 1 -> s_ready stays 0 and m_data is stable throughout; rst asserted in WRITE -> all outputs at reset values the next cycle.
